// File: rtl/diffeq_pkg.sv
// diffeq_pkg: shared state encodings and default parameters for the diffeq sequencer.
package diffeq_pkg;

  // Controller states; the numeric values are visible on the state output.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_READ    = 2'd1,
    ST_COMPUTE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  localparam int DEF_NUM_LOADS  = 4;
  localparam int DEF_NUM_PHASES = 4;
  localparam int DEF_ITER_W     = 16;

endpackage

// File: rtl/prio_onehot.sv
// prio_onehot: grants the lowest-index set bit of req as a one-hot vector.
module prio_onehot #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  logic [N-1:0] one_s;

  assign one_s = {{(N-1){1'b0}}, 1'b1};

  // Two's-complement trick: req & -req keeps only the lowest set bit.
  always_comb begin
    gnt = req & (~req + one_s);
  end

endmodule

// File: rtl/diffeq_seq_ctrl.sv
// diffeq_seq_ctrl: sequences operand loading, phased compute loop and result
// handshake for the differential-equation solver datapath.
module diffeq_seq_ctrl
  import diffeq_pkg::*;
#(
  parameter int NUM_LOADS  = DEF_NUM_LOADS,
  parameter int NUM_PHASES = DEF_NUM_PHASES,
  parameter int ITER_W     = DEF_ITER_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          abort,
  input  logic [NUM_LOADS-1:0]          load_req,
  input  logic                          ready,
  input  logic                          phase_done,
  input  logic                          continue_while,
  input  logic [ITER_W-1:0]             max_iter,
  input  logic                          out_ack,
  output logic [NUM_LOADS-1:0]          load_en,
  output logic [$clog2(NUM_PHASES)-1:0] phase,
  output logic [ITER_W-1:0]             iter_count,
  output logic                          busy,
  output logic                          valid,
  output logic                          timeout,
  output logic [1:0]                    state
);

  localparam int PH_W = $clog2(NUM_PHASES);
  localparam logic [PH_W-1:0]      LAST_PHASE = PH_W'(NUM_PHASES - 1);
  localparam logic [NUM_LOADS-1:0] ALL_LOADED = {NUM_LOADS{1'b1}};
  localparam logic [NUM_LOADS-1:0] NO_LOADS   = {NUM_LOADS{1'b0}};
  localparam logic [ITER_W-1:0]    ITER_MAX   = {ITER_W{1'b1}};
  localparam logic [ITER_W-1:0]    ITER_ZERO  = {ITER_W{1'b0}};
  localparam logic [PH_W-1:0]      PH_ZERO    = {PH_W{1'b0}};

  state_e               state_r, state_nxt_s;
  logic [NUM_LOADS-1:0] load_en_r, load_en_nxt_s;
  logic [NUM_LOADS-1:0] mask_r, mask_nxt_s;
  logic [PH_W-1:0]      phase_r, phase_nxt_s;
  logic [ITER_W-1:0]    iter_r, iter_nxt_s;
  logic                 timeout_r, timeout_nxt_s;
  logic                 busy_r, busy_nxt_s;
  logic                 valid_r, valid_nxt_s;

  logic [NUM_LOADS-1:0] grant_s;
  logic [NUM_LOADS-1:0] mask_all_s;
  logic [ITER_W-1:0]    iter_inc_s;
  logic [ITER_W:0]      iter_plus_s;
  logic                 loop_ok_s;

  // Only channels not yet loaded compete, so a held request walks upward.
  prio_onehot #(.N(NUM_LOADS)) u_prio (
    .req (load_req & ~mask_r),
    .gnt (grant_s)
  );

  assign mask_all_s  = mask_r | grant_s;
  assign iter_inc_s  = (iter_r == ITER_MAX) ? iter_r : (iter_r + ITER_W'(1'b1));
  assign iter_plus_s = {1'b0, iter_r} + {{ITER_W{1'b0}}, 1'b1};
  assign loop_ok_s   = (max_iter == ITER_ZERO) || (iter_plus_s < {1'b0, max_iter});

  // Next-state and next-output decode; abort overrides every transition.
  always_comb begin
    state_nxt_s   = state_r;
    load_en_nxt_s = NO_LOADS;
    mask_nxt_s    = mask_r;
    phase_nxt_s   = phase_r;
    iter_nxt_s    = iter_r;
    timeout_nxt_s = timeout_r;
    if (abort) begin
      state_nxt_s = ST_IDLE;
      mask_nxt_s  = NO_LOADS;
      phase_nxt_s = PH_ZERO;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_nxt_s   = ST_READ;
            mask_nxt_s    = NO_LOADS;
            iter_nxt_s    = ITER_ZERO;
            timeout_nxt_s = 1'b0;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_READ: begin
          load_en_nxt_s = grant_s;
          mask_nxt_s    = mask_all_s;
          if (ready && (mask_all_s == ALL_LOADED)) begin
            state_nxt_s = ST_COMPUTE;
            phase_nxt_s = PH_ZERO;
            iter_nxt_s  = ITER_ZERO;
          end else begin
            state_nxt_s = ST_READ;
          end
        end
        ST_COMPUTE: begin
          if (!phase_done) begin
            state_nxt_s = ST_COMPUTE;
          end else if (phase_r != LAST_PHASE) begin
            phase_nxt_s = phase_r + PH_W'(1'b1);
          end else begin
            phase_nxt_s = PH_ZERO;
            iter_nxt_s  = iter_inc_s;
            if (!continue_while) begin
              state_nxt_s = ST_DONE;
            end else if (loop_ok_s) begin
              state_nxt_s = ST_COMPUTE;
            end else begin
              state_nxt_s   = ST_DONE;
              timeout_nxt_s = 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (out_ack) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_DONE;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          mask_nxt_s  = NO_LOADS;
          phase_nxt_s = PH_ZERO;
        end
      endcase
    end
    busy_nxt_s  = (state_nxt_s == ST_READ) || (state_nxt_s == ST_COMPUTE);
    valid_nxt_s = (state_nxt_s == ST_DONE);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      load_en_r <= NO_LOADS;
      mask_r    <= NO_LOADS;
      phase_r   <= PH_ZERO;
      iter_r    <= ITER_ZERO;
      timeout_r <= 1'b0;
      busy_r    <= 1'b0;
      valid_r   <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      load_en_r <= load_en_nxt_s;
      mask_r    <= mask_nxt_s;
      phase_r   <= phase_nxt_s;
      iter_r    <= iter_nxt_s;
      timeout_r <= timeout_nxt_s;
      busy_r    <= busy_nxt_s;
      valid_r   <= valid_nxt_s;
    end
  end

  assign state      = state_r;
  assign load_en    = load_en_r;
  assign phase      = phase_r;
  assign iter_count = iter_r;
  assign timeout    = timeout_r;
  assign busy       = busy_r;
  assign valid      = valid_r;

endmodule

// File: tb/tb_diffeq_seq_ctrl.sv
// tb_diffeq_seq_ctrl: directed scenarios plus randomized run against a reference model.
module tb_diffeq_seq_ctrl;

  localparam int NL = 4, NP = 4, IW = 16;
  localparam int BNL = 6, BNP = 3, BIW = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Instance A: default parameters
  logic start, abort, ready, phase_done, continue_while, out_ack;
  logic [NL-1:0] load_req, load_en;
  logic [IW-1:0] max_iter, iter_count;
  logic [1:0] phase, state;
  logic busy, valid, timeout;

  // Instance B: 6 loads, 3 phases, 4-bit iteration counter
  logic b_start, b_abort, b_ready, b_phase_done, b_continue_while, b_out_ack;
  logic [BNL-1:0] b_load_req, b_load_en;
  logic [BIW-1:0] b_max_iter, b_iter_count;
  logic [1:0] b_phase, b_state;
  logic b_busy, b_valid, b_timeout;

  int n_checks = 0;
  int n_pass = 0;

  // Reference model state
  int m_state, m_load_en, m_mask, m_phase, m_iter, m_timeout;

  diffeq_seq_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .load_req(load_req),
    .ready(ready), .phase_done(phase_done), .continue_while(continue_while),
    .max_iter(max_iter), .out_ack(out_ack), .load_en(load_en), .phase(phase),
    .iter_count(iter_count), .busy(busy), .valid(valid), .timeout(timeout), .state(state)
  );

  diffeq_seq_ctrl #(.NUM_LOADS(BNL), .NUM_PHASES(BNP), .ITER_W(BIW)) dut_b (
    .clk(clk), .reset(reset), .start(b_start), .abort(b_abort), .load_req(b_load_req),
    .ready(b_ready), .phase_done(b_phase_done), .continue_while(b_continue_while),
    .max_iter(b_max_iter), .out_ack(b_out_ack), .load_en(b_load_en), .phase(b_phase),
    .iter_count(b_iter_count), .busy(b_busy), .valid(b_valid), .timeout(b_timeout), .state(b_state)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    start = 1'b0; abort = 1'b0; load_req = '0; ready = 1'b0; phase_done = 1'b0;
    continue_while = 1'b0; max_iter = '0; out_ack = 1'b0;
    b_start = 1'b0; b_abort = 1'b0; b_load_req = '0; b_ready = 1'b0; b_phase_done = 1'b0;
    b_continue_while = 1'b0; b_max_iter = '0; b_out_ack = 1'b0;
  endtask

  // Behavioural reference for instance A: predicts outputs after the next edge.
  task automatic model_step(input logic st, input logic ab, input logic [NL-1:0] lr,
                            input logic rdy, input logic pd, input logic cw,
                            input int mx, input logic ack);
    int g;
    g = 0;
    if (ab) begin
      m_state = 0; m_load_en = 0; m_mask = 0; m_phase = 0;
    end else begin
      m_load_en = 0;
      case (m_state)
        0: if (st) begin m_state = 1; m_iter = 0; m_timeout = 0; m_mask = 0; end
        1: begin
          for (int i = 0; i < NL; i++)
            if (g == 0 && lr[i] && ((m_mask >> i) & 1) == 0) g = 1 << i;
          m_load_en = g;
          m_mask = m_mask | g;
          if (rdy && m_mask == (1 << NL) - 1) begin m_state = 2; m_phase = 0; m_iter = 0; end
        end
        2: if (pd) begin
          if (m_phase < NP - 1) m_phase = m_phase + 1;
          else begin
            m_phase = 0;
            if (!cw) m_state = 3;
            else if (!(mx == 0 || m_iter + 1 < mx)) begin m_state = 3; m_timeout = 1; end
            if (m_iter < (1 << IW) - 1) m_iter = m_iter + 1;
          end
        end
        3: if (ack) m_state = 0;
        default: m_state = 0;
      endcase
    end
  endtask

  task automatic do_load_a();
    start = 1'b1; cyc(); start = 1'b0;
    load_req = 4'hF; ready = 1'b1;
    for (int i = 0; i < 20 && state != 2'd2; i++) cyc();
    n_checks++;
    if (state !== 2'd2) $display("FAIL load_a_reach_compute: state=%0d expected 2", state); else n_pass++;
    load_req = 4'h0; ready = 1'b0;
  endtask

  task automatic test_reset();
    idle_all();
    reset = 1'b1;
    #3;
    n_checks++;
    if ({state, load_en, phase, iter_count, busy, valid, timeout} !== '0)
      $display("FAIL reset_a: st=%0d le=%0h ph=%0d it=%0d b=%0b v=%0b to=%0b expected all 0",
               state, load_en, phase, iter_count, busy, valid, timeout);
    else n_pass++;
    n_checks++;
    if ({b_state, b_load_en, b_iter_count, b_valid} !== '0)
      $display("FAIL reset_b: st=%0d le=%0h it=%0d v=%0b expected 0", b_state, b_load_en, b_iter_count, b_valid);
    else n_pass++;
    #9 reset = 1'b0;
    cyc();
    n_checks++;
    if (state !== 2'd0 || busy !== 1'b0) $display("FAIL reset_release: state=%0d busy=%0b expected 0/0", state, busy); else n_pass++;
  endtask

  task automatic test_load_sequence();
    start = 1'b1; cyc(); start = 1'b0;
    n_checks++;
    if (state !== 2'd1 || busy !== 1'b1) $display("FAIL start_to_read: state=%0d busy=%0b expected 1/1", state, busy); else n_pass++;
    load_req = 4'hF; ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      n_checks++;
      if (load_en !== 4'(1 << k)) $display("FAIL grant_%0d: load_en=%b expected %b", k, load_en, 4'(1 << k)); else n_pass++;
      n_checks++;
      if (state !== ((k < 3) ? 2'd1 : 2'd2)) $display("FAIL grant_state_%0d: state=%0d", k, state); else n_pass++;
    end
    load_req = 4'h0; ready = 1'b0;
    cyc();
    n_checks++;
    if (load_en !== 4'h0 || phase !== 2'd0 || iter_count !== 16'd0)
      $display("FAIL compute_entry: le=%b ph=%0d it=%0d expected 0/0/0", load_en, phase, iter_count);
    else n_pass++;
  endtask

  task automatic test_loop();
    max_iter = 16'd0; phase_done = 1'b1;
    for (int it = 0; it < 4; it++)
      for (int p = 0; p < 4; p++) begin
        n_checks++;
        if (phase !== 2'(p) || state !== 2'd2)
          $display("FAIL loop_phase_i%0d_p%0d: phase=%0d state=%0d expected %0d/2", it, p, phase, state, p);
        else n_pass++;
        continue_while = (it < 3);
        cyc();
      end
    phase_done = 1'b0;
    n_checks++;
    if (state !== 2'd3 || valid !== 1'b1 || busy !== 1'b0 || iter_count !== 16'd4 || timeout !== 1'b0)
      $display("FAIL loop_done: st=%0d v=%0b b=%0b it=%0d to=%0b expected 3/1/0/4/0", state, valid, busy, iter_count, timeout);
    else n_pass++;
    cyc(); cyc();
    n_checks++;
    if (valid !== 1'b1) $display("FAIL valid_hold: valid=%0b expected 1", valid); else n_pass++;
    out_ack = 1'b1; cyc(); out_ack = 1'b0;
    phase_done = 1'b1; cyc(); phase_done = 1'b0;
    n_checks++;
    if (state !== 2'd0 || valid !== 1'b0 || iter_count !== 16'd4 || phase !== 2'd0)
      $display("FAIL ack_to_idle: st=%0d v=%0b it=%0d ph=%0d expected 0/0/4/0", state, valid, iter_count, phase);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int cnt;
    do_load_a();
    max_iter = 16'd2; continue_while = 1'b1; phase_done = 1'b1;
    cnt = 0;
    while (state != 2'd3 && cnt < 50) begin cyc(); cnt++; end
    phase_done = 1'b0;
    n_checks++;
    if (cnt !== 8 || iter_count !== 16'd2 || timeout !== 1'b1)
      $display("FAIL timeout_exit: edges=%0d it=%0d to=%0b expected 8/2/1", cnt, iter_count, timeout);
    else n_pass++;
    out_ack = 1'b1; cyc(); out_ack = 1'b0;
    n_checks++;
    if (state !== 2'd0 || timeout !== 1'b1 || iter_count !== 16'd2)
      $display("FAIL timeout_hold_idle: st=%0d to=%0b it=%0d expected 0/1/2", state, timeout, iter_count);
    else n_pass++;
    start = 1'b1; cyc(); start = 1'b0;
    n_checks++;
    if (state !== 2'd1 || timeout !== 1'b0 || iter_count !== 16'd0)
      $display("FAIL start_clears: st=%0d to=%0b it=%0d expected 1/0/0", state, timeout, iter_count);
    else n_pass++;
    abort = 1'b1; cyc(); abort = 1'b0;
  endtask

  task automatic test_abort();
    do_load_a();
    max_iter = 16'd0; continue_while = 1'b1; phase_done = 1'b1;
    for (int i = 0; i < 30 && !(phase == 2'd2 && iter_count == 16'd1); i++) cyc();
    abort = 1'b1; cyc(); abort = 1'b0; phase_done = 1'b0;
    n_checks++;
    if (state !== 2'd0 || load_en !== 4'h0 || phase !== 2'd0 || iter_count !== 16'd1 || busy !== 1'b0)
      $display("FAIL abort_compute: st=%0d le=%b ph=%0d it=%0d b=%0b expected 0/0/0/1/0", state, load_en, phase, iter_count, busy);
    else n_pass++;
    start = 1'b1; cyc(); start = 1'b0;
    load_req = 4'hF; ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      n_checks++;
      if (load_en !== 4'(1 << k)) $display("FAIL reread_%0d: load_en=%b expected %b", k, load_en, 4'(1 << k)); else n_pass++;
    end
    load_req = 4'h0; ready = 1'b0;
    abort = 1'b1; cyc(); abort = 1'b0;
  endtask

  task automatic test_partial_ready();
    start = 1'b1; cyc(); start = 1'b0;
    load_req = 4'b0011; ready = 1'b1;
    cyc();
    cyc();
    n_checks++;
    if (load_en !== 4'b0010) $display("FAIL partial_grant2: load_en=%b expected 0010", load_en); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_checks++;
      if (state !== 2'd1 || load_en !== 4'h0) $display("FAIL partial_stay_%0d: st=%0d le=%b expected 1/0000", i, state, load_en); else n_pass++;
    end
    load_req = 4'b1100;
    cyc(); cyc();
    n_checks++;
    if (state !== 2'd2 || load_en !== 4'b1000) $display("FAIL partial_finish: st=%0d le=%b expected 2/1000", state, load_en); else n_pass++;
    load_req = 4'h0; ready = 1'b0;
    abort = 1'b1; cyc(); abort = 1'b0;
  endtask

  task automatic test_reset_done();
    do_load_a();
    continue_while = 1'b0; phase_done = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    phase_done = 1'b0;
    n_checks++;
    if (valid !== 1'b1 || iter_count !== 16'd1) $display("FAIL pre_reset_done: v=%0b it=%0d expected 1/1", valid, iter_count); else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (valid !== 1'b0 || state !== 2'd0 || iter_count !== 16'd0)
      $display("FAIL async_reset_done: v=%0b st=%0d it=%0d expected 0/0/0", valid, state, iter_count);
    else n_pass++;
    #3 reset = 1'b0;
    cyc();
    n_checks++;
    if (valid !== 1'b0 || busy !== 1'b0 || state !== 2'd0 || load_en !== 4'h0)
      $display("FAIL reset_release_quiet: v=%0b b=%0b st=%0d le=%b expected 0", valid, busy, state, load_en);
    else n_pass++;
  endtask

  task automatic b_load();
    b_start = 1'b1; cyc(); b_start = 1'b0;
    b_load_req = 6'h3F; b_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cyc();
      n_checks++;
      if (b_load_en !== 6'(1 << k)) $display("FAIL b_grant_%0d: load_en=%b expected %b", k, b_load_en, 6'(1 << k)); else n_pass++;
    end
    b_load_req = 6'h0; b_ready = 1'b0;
    n_checks++;
    if (b_state !== 2'd2) $display("FAIL b_compute_entry: state=%0d expected 2", b_state); else n_pass++;
  endtask

  task automatic test_b_params();
    b_load();
    b_max_iter = 4'd0; b_phase_done = 1'b1;
    for (int it = 0; it < 4; it++)
      for (int p = 0; p < 3; p++) begin
        n_checks++;
        if (b_phase !== 2'(p)) $display("FAIL b_phase_i%0d_p%0d: phase=%0d expected %0d", it, p, b_phase, p); else n_pass++;
        b_continue_while = (it < 3);
        cyc();
      end
    b_phase_done = 1'b0;
    n_checks++;
    if (b_state !== 2'd3 || b_iter_count !== 4'd4 || b_timeout !== 1'b0)
      $display("FAIL b_loop_done: st=%0d it=%0d to=%0b expected 3/4/0", b_state, b_iter_count, b_timeout);
    else n_pass++;
    b_out_ack = 1'b1; cyc(); b_out_ack = 1'b0;
    b_load();
    b_continue_while = 1'b1; b_phase_done = 1'b1;
    for (int i = 0; i < 60; i++) cyc();
    n_checks++;
    if (b_iter_count !== 4'hF || b_state !== 2'd2) $display("FAIL b_saturate: it=%0d st=%0d expected 15/2", b_iter_count, b_state); else n_pass++;
    b_continue_while = 1'b0;
    for (int i = 0; i < 10 && b_state != 2'd3; i++) cyc();
    b_phase_done = 1'b0;
    n_checks++;
    if (b_state !== 2'd3 || b_iter_count !== 4'hF || b_timeout !== 1'b0)
      $display("FAIL b_sat_done: st=%0d it=%0d to=%0b expected 3/15/0", b_state, b_iter_count, b_timeout);
    else n_pass++;
    b_out_ack = 1'b1; cyc(); b_out_ack = 1'b0;
  endtask

  task automatic test_random();
    logic [1:0] es, ep;
    logic [NL-1:0] ele;
    logic [IW-1:0] eit;
    logic eb, ev, eto;
    int mx;
    idle_all();
    #2 reset = 1'b1; #4 reset = 1'b0;
    cyc();
    m_state = 0; m_load_en = 0; m_mask = 0; m_phase = 0; m_iter = 0; m_timeout = 0;
    for (int c = 0; c < 2000; c++) begin
      start = ($urandom_range(0, 7) == 0);
      abort = ($urandom_range(0, 63) == 0);
      load_req = 4'($urandom_range(0, 15));
      ready = 1'($urandom_range(0, 1));
      phase_done = ($urandom_range(0, 3) != 0);
      continue_while = ($urandom_range(0, 3) != 0);
      mx = $urandom_range(0, 4);
      max_iter = 16'(mx);
      out_ack = ($urandom_range(0, 2) == 0);
      model_step(start, abort, load_req, ready, phase_done, continue_while, mx, out_ack);
      cyc();
      es = 2'(m_state); ep = 2'(m_phase); ele = 4'(m_load_en); eit = 16'(m_iter);
      eto = (m_timeout != 0); eb = (m_state == 1 || m_state == 2); ev = (m_state == 3);
      n_checks++;
      if ({state, phase, load_en, iter_count, timeout, busy, valid} !== {es, ep, ele, eit, eto, eb, ev})
        $display("FAIL random_c%0d: st=%0d ph=%0d le=%b it=%0d to=%0b b=%0b v=%0b expected %0d %0d %b %0d %0b %0b %0b",
                 c, state, phase, load_en, iter_count, timeout, busy, valid, es, ep, ele, eit, eto, eb, ev);
      else n_pass++;
    end
    idle_all();
  endtask

  initial begin
    test_reset();
    test_load_sequence();
    test_loop();
    test_timeout();
    test_abort();
    test_partial_ready();
    test_reset_done();
    test_b_params();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
